i2c_gain_slave: RTL and testbench
=================================

Name: i2c_gain_slave

Overview:
- I2C slave (responder) that terminates the equalizer's configuration bus.
- Decodes master write transactions of the form START, {addr,W}, reg, data..., STOP.
- Stores one 8-bit gain per band, mapped 0 = -24 dB, 255 = +24 dB.
- Presents all gains in parallel to the filter bank, with a one-cycle update strobe per accepted write.

Parameters:
- SLAVE_ADDR, 7'h2A: 7-bit bus address the block answers to.
- NUM_BANDS, 10: number of gain registers, mapped to register addresses 0x01..NUM_BANDS.
- GAIN_RESET, 8'd128: reset value of every gain register (about 0 dB).
- SYNC_STAGES, 2: synchronizer depth on SCL and SDA.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset.
- i2c_scl  in  1  I2C clock from master.
- i2c_sda_in  in  1  sampled SDA line.
- i2c_sda_oe  out  1  1 = pull SDA low. Top level drives i2c_sda = oe ? 1'b0 : 1'bz.
- gains  out  8*NUM_BANDS  band k (k = 0..NUM_BANDS-1) occupies bits [8k+7:8k] and holds register 0x01+k.
- gain_update  out  1  one-cycle pulse when a gain register is written.
- gain_index  out  8  register address written; valid while gain_update = 1.
- busy  out  1  high between START and STOP.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state = IDLE, i2c_sda_oe = 0, every gain = GAIN_RESET, gain_update = 0, gain_index = 0, busy = 0, register pointer = 0.
- Sampling: SCL and SDA pass through SYNC_STAGES flops. Edges are detected on the synchronized values.
- Bus timing requirement: SCL high and low phases of at least 4 clk cycles each.
- START: SDA falls while SCL is high. Accepted in any state, including mid-byte (repeated START): bit counter clears, busy = 1, go to ADDR.
- STOP: SDA rises while SCL is high. Go to IDLE, busy = 0, i2c_sda_oe released. A partial byte is discarded.
- Data bits are shifted MSB-first on SCL rising edges. A 3-bit counter counts 8 bits.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
- ADDR: after 8 bits, if byte[7:1] == SLAVE_ADDR and R/W = 0, go to ADDR_ACK. Otherwise go to IGNORE, with SDA never driven.
- ACK timing: on the SCL falling edge that ends bit 8, assert i2c_sda_oe. Release it on the SCL falling edge that ends bit 9.
- REG: the received byte loads the register pointer, then REG_ACK. The register byte is always ACKed.
- DATA:
  - If pointer is in 0x01..NUM_BANDS: write the gain, pulse gain_update with gain_index = pointer on the cycle after bit 8 is sampled, then DATA_ACK with ACK.
  - Otherwise: no write, and the ACK slot is NACKed (SDA left high).
  - In both cases the pointer then increments, modulo 256, and the next byte is taken as DATA (auto-increment burst).
- IGNORE: stay until START or STOP.
- Master releases SDA during an ACK slot: the value the master reads is don't-care to this block. It never samples its own ACK.
- Simultaneous events: a STOP/START detected in the same cycle as an SCL edge takes priority. SDA changes while SCL is high are never treated as data.
- Reset asserted mid-transaction: next cycle i2c_sda_oe = 0, state = IDLE, gains = GAIN_RESET.

Optional Feature:
- Macro: I2C_GAIN_READ_EN.
- Defined: an address byte with R/W = 1 is ACKed. The slave then drives bytes from the current pointer, MSB-first:
  - i2c_sda_oe = ~bit, updated on each SCL falling edge.
  - Out-of-range registers read 8'h00.
  - Pointer increments after each byte.
  - Master ACK continues the burst. Master NACK sends the block to IGNORE until STOP.
  - Adds a DATA_TX state.
- Undefined: an address byte with R/W = 1 is NACKed and the block goes to IGNORE.

Test Plan:
- Reset, then read gains → every byte = 8'd128, i2c_sda_oe = 0, busy = 0.
- Write 0x2A/W, reg 0x03, data 0x0F → ACK on all 3 bytes; gains[23:16] = 0x0F; one gain_update pulse with gain_index = 0x03; other bands stay at 128.
- Burst: reg 0x09, data 0x2D, 0x32, 0x44 → band 0x09 = 0x2D and band 0x0A = 0x32, both ACKed; third byte (pointer 0x0B) NACKed, no update pulse.
- Address 0x55 → no ACK, SDA never driven, gains unchanged, IGNORE until STOP.
- Repeated START after the register byte, then a full write to reg 0x01 data 0x05 → band 0x01 = 0x05. STOP in the middle of a data byte → no write.
- Reset pulse mid-data-byte → i2c_sda_oe = 0 next cycle, gains return to 128. With I2C_GAIN_READ_EN defined: set pointer to 0x01, then read → returns 0x05.

Source files
------------

// File: rtl/i2c_gain_slave.sv
// I2C responder holding one 8-bit gain per equalizer band (0 = -24 dB, 255 = +24 dB).
// Define I2C_GAIN_READ_EN to also serve read transactions from the register pointer.
module i2c_gain_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         NUM_BANDS   = 10,
    parameter logic [7:0] GAIN_RESET  = 8'd128,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i2c_scl,
    input  logic                   i2c_sda_in,
    output logic                   i2c_sda_oe,
    output logic [8*NUM_BANDS-1:0] gains,
    output logic                   gain_update,
    output logic [7:0]             gain_index,
    output logic                   busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
        DATA, DATA_ACK, IGNORE, DATA_TX
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] ptr;
    logic       ack_ok, ack_drv;
    logic [7:0] gain_q [NUM_BANDS];
    logic [7:0] rx_byte;
    logic       byte_done, addr_ok, in_range;
`ifdef I2C_GAIN_READ_EN
    logic       rw_q, tx_ack;
    logic [7:0] tx_byte;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // START/STOP need SCL high on both samples, so they never coincide with an SCL edge
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    for (genvar k = 0; k < NUM_BANDS; k++) begin : g_out
        assign gains[8*k +: 8] = gain_q[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR: begin
                    if (byte_done) state_d = addr_ok ? ADDR_ACK : IGNORE;
                end
                ADDR_ACK: begin
                    if (scl_fall && ack_drv) begin
`ifdef I2C_GAIN_READ_EN
                        state_d = rw_q ? DATA_TX : REG;
`else
                        state_d = REG;
`endif
                    end
                end
                REG: begin
                    if (byte_done) state_d = REG_ACK;
                end
                REG_ACK: begin
                    if (scl_fall && ack_drv) state_d = DATA;
                end
                DATA: begin
                    if (byte_done) state_d = DATA_ACK;
                end
                DATA_ACK: begin
                    if (scl_fall && ack_drv) state_d = DATA;
                end
`ifdef I2C_GAIN_READ_EN
                DATA_TX: begin
                    if (scl_rise && tx_ack && sda_s) state_d = IGNORE;
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_byte   = {shreg, sda_s};
        byte_done = scl_rise && (bit_cnt == 3'd7);
        in_range  = (ptr != 8'd0) && (ptr <= 8'(NUM_BANDS));
`ifdef I2C_GAIN_READ_EN
        addr_ok   = (rx_byte[7:1] == SLAVE_ADDR);
        tx_byte   = 8'h00;
        for (int k = 0; k < NUM_BANDS; k++) begin
            if (ptr == 8'(k + 1)) tx_byte = gain_q[k];
        end
`else
        addr_ok   = (rx_byte[7:1] == SLAVE_ADDR) && !rx_byte[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            ptr         <= 8'd0;
            ack_ok      <= 1'b0;
            ack_drv     <= 1'b0;
            i2c_sda_oe  <= 1'b0;
            gain_update <= 1'b0;
            gain_index  <= 8'd0;
            busy        <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) gain_q[k] <= GAIN_RESET;
`ifdef I2C_GAIN_READ_EN
            rw_q        <= 1'b0;
            tx_ack      <= 1'b0;
`endif
        end else begin
            gain_update <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt    <= 3'd0;
                ack_drv    <= 1'b0;
                i2c_sda_oe <= 1'b0;
                busy       <= start_det;
`ifdef I2C_GAIN_READ_EN
                tx_ack     <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ADDR, REG, DATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_ok <= 1'b1;
`ifdef I2C_GAIN_READ_EN
                                if (state_q == ADDR) rw_q <= rx_byte[0];
`endif
                                if (state_q == REG) ptr <= rx_byte;
                                if (state_q == DATA) begin
                                    ack_ok <= in_range;
                                    ptr    <= ptr + 8'd1;
                                    for (int k = 0; k < NUM_BANDS; k++) begin
                                        if (ptr == 8'(k + 1)) gain_q[k] <= rx_byte;
                                    end
                                    if (in_range) begin
                                        gain_update <= 1'b1;
                                        gain_index  <= ptr;
                                    end
                                end
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, DATA_ACK: begin
                        // first fall opens the ACK slot, second fall closes it
                        if (scl_fall) begin
                            ack_drv <= ~ack_drv;
                            if (!ack_drv) begin
                                i2c_sda_oe <= ack_ok;
                            end else begin
                                i2c_sda_oe <= 1'b0;
`ifdef I2C_GAIN_READ_EN
                                if (state_q == ADDR_ACK && rw_q) begin
                                    i2c_sda_oe <= ~tx_byte[7];
                                    tx_ack     <= 1'b0;
                                end
`endif
                            end
                        end
                    end
`ifdef I2C_GAIN_READ_EN
                    DATA_TX: begin
                        if (scl_rise) begin
                            if (tx_ack) begin
                                tx_ack <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    tx_ack <= 1'b1;
                                    ptr    <= ptr + 8'd1;
                                end
                            end
                        end else if (scl_fall) begin
                            i2c_sda_oe <= tx_ack ? 1'b0 : ~tx_byte[3'd7 - bit_cnt];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_gain_slave.sv
// Bench for i2c_gain_slave: bit-banged I2C master, wired-AND SDA, update scoreboard.
module tb_i2c_gain_slave;

    localparam int NB = 10;
    localparam int Q  = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl   = 1'b1;
    logic          msda  = 1'b1;
    logic          sda_line;
    logic          sda_oe;
    logic          gain_update;
    logic          busy;
    logic [7:0]    gain_index;
    logic [8*NB-1:0] gains;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] val;
    } upd_t;

    upd_t       exp_q[$];
    logic [7:0] model [NB];
    int         vectors = 0;
    int         errors  = 0;
    int         oe_cnt  = 0;

    assign sda_line = msda & ~sda_oe;

    i2c_gain_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i2c_scl    (scl),
        .i2c_sda_in (sda_line),
        .i2c_sda_oe (sda_oe),
        .gains      (gains),
        .gain_update(gain_update),
        .gain_index (gain_index),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // every wait goes through here; update pulses are popped against the scoreboard
    task automatic tick(input int n);
        upd_t e;
        int   b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sda_oe) oe_cnt++;
            if (rst_n && gain_update) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_spurious idx=%02h", gain_index);
                end else begin
                    e = exp_q.pop_front();
                    b = int'(e.idx) - 1;
                    if (gain_index !== e.idx || gains[8*b +: 8] !== e.val) begin
                        errors++;
                        $display("FAIL upd idx=%02h val=%02h expected idx=%02h val=%02h",
                                 gain_index, gains[8*b +: 8], e.idx, e.val);
                    end
                end
            end
        end
    endtask

    task automatic bus_start;
        msda = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        msda = 1'b0; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic bus_stop;
        msda = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        msda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        msda = b;    tick(Q);
        scl  = 1'b1; tick(2*Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        msda = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        ack  = ~sda_line;
        tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick(4);
        rst_n = 1'b1; tick(2);
        for (int k = 0; k < NB; k++) begin
            model[k] = 8'd128;
            vectors++;
            if (gains[8*k +: 8] !== 8'd128) begin
                errors++;
                $display("FAIL reset_gain%0d got=%02h expected=80", k, gains[8*k +: 8]);
            end
        end
        vectors++;
        if ({sda_oe, busy, gain_update} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl oe/busy/upd=%03b expected 000",
                     {sda_oe, busy, gain_update});
        end
        vectors++;
        if (gain_index !== 8'h00) begin
            errors++;
            $display("FAIL reset_index got=%02h expected=00", gain_index);
        end
    endtask

    task automatic test_single_write;
        logic a0, a1, a2;
        bus_start;
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start got=%b expected=1", busy);
        end
        send_byte(8'h54, a0);
        send_byte(8'h03, a1);
        exp_q.push_back('{idx: 8'h03, val: 8'h0F});
        model[2] = 8'h0F;
        send_byte(8'h0F, a2);
        bus_stop;
        vectors++;
        if ({a0, a1, a2} !== 3'b111) begin
            errors++; $display("FAIL single_acks got=%03b expected=111", {a0, a1, a2});
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL single_upd missing=%0d expected=0", exp_q.size());
        end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (gains[8*k +: 8] !== model[k]) begin
                errors++;
                $display("FAIL single_gain%0d got=%02h expected=%02h", k, gains[8*k +: 8], model[k]);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_after_stop got=%b expected=0", busy);
        end
    endtask

    task automatic test_burst;
        logic a0, a1, a2, a3, a4;
        bus_start;
        send_byte(8'h54, a0);
        send_byte(8'h09, a1);
        exp_q.push_back('{idx: 8'h09, val: 8'h2D});
        model[8] = 8'h2D;
        send_byte(8'h2D, a2);
        exp_q.push_back('{idx: 8'h0A, val: 8'h32});
        model[9] = 8'h32;
        send_byte(8'h32, a3);
        send_byte(8'h44, a4);
        bus_stop;
        vectors++;
        if ({a0, a1, a2, a3, a4} !== 5'b11110) begin
            errors++;
            $display("FAIL burst_acks got=%05b expected=11110", {a0, a1, a2, a3, a4});
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL burst_upd missing=%0d expected=0", exp_q.size());
        end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (gains[8*k +: 8] !== model[k]) begin
                errors++;
                $display("FAIL burst_gain%0d got=%02h expected=%02h", k, gains[8*k +: 8], model[k]);
            end
        end
    endtask

    task automatic test_bad_addr;
        logic a0, a1, a2;
        int   oe0;
        oe0 = oe_cnt;
        bus_start;
        send_byte(8'hAA, a0);
        send_byte(8'h03, a1);
        send_byte(8'h77, a2);
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ignore_busy got=%b expected=1", busy);
        end
        bus_stop;
        vectors++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++; $display("FAIL badaddr_acks got=%03b expected=000", {a0, a1, a2});
        end
        vectors++;
        if (oe_cnt != oe0) begin
            errors++; $display("FAIL badaddr_oe cycles=%0d expected=0", oe_cnt - oe0);
        end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (gains[8*k +: 8] !== model[k]) begin
                errors++;
                $display("FAIL badaddr_gain%0d got=%02h expected=%02h", k, gains[8*k +: 8], model[k]);
            end
        end
    endtask

    task automatic test_repeated_start;
        logic       a0, a1, a2, a3, a4, a5, a6;
        logic [7:0] d;
        bus_start;
        send_byte(8'h54, a0);
        send_byte(8'h05, a1);
        bus_start;
        send_byte(8'h54, a2);
        send_byte(8'h01, a3);
        exp_q.push_back('{idx: 8'h01, val: 8'h05});
        model[0] = 8'h05;
        send_byte(8'h05, a4);
        bus_stop;
        // STOP in the middle of a data byte: nothing may be written
        bus_start;
        send_byte(8'h54, a5);
        send_byte(8'h02, a6);
        d = 8'hE7;
        for (int i = 7; i >= 4; i--) send_bit(d[i]);
        bus_stop;
        vectors++;
        if ({a0, a1, a2, a3, a4, a5, a6} !== 7'b1111111) begin
            errors++;
            $display("FAIL rstart_acks got=%07b expected=1111111", {a0, a1, a2, a3, a4, a5, a6});
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rstart_upd missing=%0d expected=0", exp_q.size());
        end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (gains[8*k +: 8] !== model[k]) begin
                errors++;
                $display("FAIL rstart_gain%0d got=%02h expected=%02h", k, gains[8*k +: 8], model[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic       a0, a1;
        logic [7:0] d;
        bus_start;
        send_byte(8'h54, a0);
        send_byte(8'h04, a1);
        exp_q.push_back('{idx: 8'h04, val: 8'h11});
        model[3] = 8'h11;
        d = 8'h11;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        msda = 1'b1; tick(Q);
        vectors++;
        if ({a0, a1, sda_oe} !== 3'b111) begin
            errors++; $display("FAIL mid_ack got=%03b expected=111", {a0, a1, sda_oe});
        end
        vectors++;
        if (gains[31:24] !== model[3]) begin
            errors++; $display("FAIL mid_write got=%02h expected=%02h", gains[31:24], model[3]);
        end
        rst_n = 1'b0;
        tick(1);
        vectors++;
        if ({sda_oe, busy} !== 2'b00) begin
            errors++; $display("FAIL mid_reset oe/busy=%02b expected=00", {sda_oe, busy});
        end
        for (int k = 0; k < NB; k++) begin
            model[k] = 8'd128;
            vectors++;
            if (gains[8*k +: 8] !== model[k]) begin
                errors++;
                $display("FAIL mid_gain%0d got=%02h expected=%02h", k, gains[8*k +: 8], model[k]);
            end
        end
        rst_n = 1'b1;
        scl   = 1'b1;
        tick(2*Q);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL mid_upd missing=%0d expected=0", exp_q.size());
        end
    endtask

`ifdef I2C_GAIN_READ_EN
    task automatic test_read;
        logic       a0, a1, a2, a3, a4, a5;
        logic [7:0] rd;
        bus_start;
        send_byte(8'h54, a0);
        send_byte(8'h01, a1);
        exp_q.push_back('{idx: 8'h01, val: 8'h05});
        model[0] = 8'h05;
        send_byte(8'h05, a2);
        bus_stop;
        bus_start;
        send_byte(8'h54, a3);
        send_byte(8'h01, a4);
        bus_start;
        send_byte(8'h55, a5);
        for (int i = 7; i >= 0; i--) begin
            msda = 1'b1; tick(Q);
            scl  = 1'b1; tick(Q);
            rd[i] = sda_line;
            tick(Q);
            scl  = 1'b0; tick(Q);
        end
        send_bit(1'b1);
        bus_stop;
        vectors++;
        if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin
            errors++;
            $display("FAIL read_acks got=%06b expected=111111", {a0, a1, a2, a3, a4, a5});
        end
        vectors++;
        if (rd !== model[0]) begin
            errors++; $display("FAIL read_data got=%02h expected=%02h", rd, model[0]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_burst;
        test_bad_addr;
        test_repeated_start;
        test_reset_mid;
`ifdef I2C_GAIN_READ_EN
        test_read;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
